if_stage: RTL

//   Instruction-fetch stage of the 5-stage MIPS CPU, directly downstream of the pc block.

---
 rtl/mips_pkg.sv | 19 +
 rtl/if_stage_if_id_reg.sv | 37 +++
 rtl/if_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
package mips_pkg;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } if_state_t;

  // Wraps modulo 2^32, so 32'hFFFF_FFFC advances to 32'h0.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: {instr, pc4, valid} with load, hold and bubble controls.
// Bubble wins over load; with neither asserted the contents are held.
module if_id_reg
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_bubble,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [31:0]        i_pc4,
  output logic [INSTR_W-1:0] o_instr,
  output logic [31:0]        o_pc4,
  output logic               o_valid
);

  logic [INSTR_W-1:0] r_instr;
  logic [31:0]        r_pc4;
  logic               r_valid;

  always_ff @(posedge clk) begin
    if (rst || i_bubble) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: imem req/ack handshake, stall/flush handling, IF/ID load.
// Optional stall-cycle counter port stall_cycles when IF_STAGE_PERF_EN is defined.
module if_stage
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc,
  output logic               pc_stall,
  input  logic               flush,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               id_stall,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [31:0]        if_id_pc4,
`ifdef IF_STAGE_PERF_EN
  output logic [31:0]        stall_cycles,
`endif
  output logic               if_id_valid
);

  if_state_t          r_state;
  if_state_t          w_state_nxt;
  logic               r_drop_q;
  logic [ADDR_W-1:0]  r_addr_q;
  logic [INSTR_W-1:0] r_buf_instr;
  logic [31:0]        r_buf_pc4;

  logic               w_pc_stall;
  logic               w_load;
  logic               w_bubble;
  logic               w_buf_we;
  logic               w_drop_set;
  logic               w_drop_clr;
  logic [INSTR_W-1:0] w_ld_instr;
  logic [31:0]        w_ld_pc4;
  logic [31:0]        w_pc4;

  assign w_pc4 = pc_plus4(pc);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_stall  = 1'b1;
    w_load      = 1'b0;
    w_bubble    = 1'b0;
    w_buf_we    = 1'b0;
    w_drop_set  = 1'b0;
    w_drop_clr  = 1'b0;
    w_ld_instr  = imem_rdata;
    w_ld_pc4    = w_pc4;
    case (r_state)
      IDLE: w_state_nxt = REQ;
      REQ: begin
        if (flush) begin
          // An unacked request must still complete, so it is tracked and its data dropped.
          w_bubble   = 1'b1;
          w_drop_set = !imem_ack;
          w_drop_clr = imem_ack;
        end else if (imem_ack && r_drop_q) begin
          w_drop_clr = 1'b1;
          w_bubble   = !id_stall;
        end else if (imem_ack) begin
          if (!id_stall) begin
            w_load     = 1'b1;
            w_pc_stall = 1'b0;
          end else begin
            w_buf_we    = 1'b1;
            w_state_nxt = HOLD;
          end
        end else begin
          w_bubble = !id_stall;
        end
      end
      HOLD: begin
        if (flush) begin
          w_bubble    = 1'b1;
          w_state_nxt = REQ;
        end else if (!id_stall) begin
          w_load      = 1'b1;
          w_ld_instr  = r_buf_instr;
          w_ld_pc4    = r_buf_pc4;
          w_pc_stall  = 1'b0;
          w_state_nxt = REQ;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_drop_q <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_drop_set)      r_drop_q <= 1'b1;
      else if (w_drop_clr) r_drop_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!r_drop_q) r_addr_q <= pc[ADDR_W-1:0];
    if (w_buf_we) begin
      r_buf_instr <= imem_rdata;
      r_buf_pc4   <= w_pc4;
    end
  end

  assign pc_stall  = rst | w_pc_stall;
  assign imem_req  = (r_state == REQ);
  assign imem_addr = r_drop_q ? r_addr_q : pc[ADDR_W-1:0];

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_bubble (w_bubble),
    .i_instr  (w_ld_instr),
    .i_pc4    (w_ld_pc4),
    .o_instr  (if_id_instr),
    .o_pc4    (if_id_pc4),
    .o_valid  (if_id_valid)
  );

`ifdef IF_STAGE_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (pc_stall && (r_stall_cnt != 32'hFFFF_FFFF))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cycles = r_stall_cnt;
`endif

endmodule
